// File: rtl/dcache_assoc.sv
// dcache_assoc -- fully-associative, write-back, write-allocate data cache.
//
// A lookup runs combinationally in IDLE whenever MEM_ld or MEM_str is high.
// A hit completes in the same cycle. A miss stalls the pipeline, optionally
// writes back a dirty victim (WB), refills the line (FILL), and then replays
// the access in IDLE.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   MEM_ld / MEM_str          load / store request (both high = load+store)
//   MEM_byt                   byte access (low byte only)
//   MEM_alu_out               word address; MEM_b2 store data
//   MEM_data_mem              load data, or MEM_alu_out when no load hits
//   MEM_stall                 pipeline hold
//   Dc_mem_req/Dc_mem_addr    refill request and line address
//   MEM_data_line/MEM_mem_valid  refill data and its valid strobe
//   Dc_wb_we/Dc_wb_addr/Dc_wb_wline  victim write-back
//   Dc_wb_ready               write-back accepted
//
// Optional: define DCACHE_PERF_EN to add the saturating 32-bit
// Dc_hit_cnt / Dc_miss_cnt outputs.
module dcache_assoc #(
  parameter int XLEN  = 32,
  parameter int LINES = 4,
  parameter int WORDS = 4,
  parameter int LADDR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_ld,
  input  logic                  MEM_str,
  input  logic                  MEM_byt,
  input  logic [XLEN-1:0]       MEM_alu_out,
  input  logic [XLEN-1:0]       MEM_b2,
  output logic [XLEN-1:0]       MEM_data_mem,
  output logic                  MEM_stall,
  output logic                  Dc_mem_req,
  output logic [LADDR-1:0]      Dc_mem_addr,
  input  logic [WORDS*XLEN-1:0] MEM_data_line,
  input  logic                  MEM_mem_valid,
  output logic                  Dc_wb_we,
  output logic [LADDR-1:0]      Dc_wb_addr,
  output logic [WORDS*XLEN-1:0] Dc_wb_wline,
  input  logic                  Dc_wb_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]           Dc_hit_cnt,
  output logic [31:0]           Dc_miss_cnt
`endif
);

  localparam int OFFB = $clog2(WORDS);
  localparam int IDXB = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t state, state_nx;

  logic [LINES-1:0]                       valid, dirty;
  logic [LINES-1:0][LADDR-1:0]            tag;
  logic [LINES-1:0][WORDS-1:0][XLEN-1:0]  data;

  logic [IDXB-1:0]  rr, victim, vsel, hit_idx, inv_idx;
  logic [LADDR-1:0] miss_line, line;
  logic [OFFB-1:0]  offset;
  logic [LINES-1:0] match;
  logic             access, hit, miss, any_inv;
  logic [XLEN-1:0]  cur_word;

  assign offset = MEM_alu_out[OFFB-1:0];
  assign line   = MEM_alu_out[OFFB+LADDR-1:OFFB];

  for (genvar i = 0; i < LINES; i++) begin : g_match
    assign match[i] = valid[i] && (tag[i] == line);
  end

  // Scan high-to-low so the lowest matching / invalid index wins.
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    any_inv = 1'b0;
    for (int i = LINES-1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDXB'(i);
      if (!valid[i]) begin
        inv_idx = IDXB'(i);
        any_inv = 1'b1;
      end
    end
  end

  assign access   = (state == IDLE) && (MEM_ld || MEM_str);
  assign hit      = access && (|match);
  assign miss     = access && !(|match);
  assign vsel     = any_inv ? inv_idx : rr;
  assign cur_word = data[hit_idx][offset];

  // The read is taken from current contents, so load+store returns pre-write data.
  assign MEM_data_mem = (hit && MEM_ld)
                        ? (MEM_byt ? {{(XLEN-8){1'b0}}, cur_word[7:0]} : cur_word)
                        : MEM_alu_out;

  assign Dc_mem_addr = miss_line;
  assign Dc_wb_addr  = (state == WB) ? tag[victim]  : '0;
  assign Dc_wb_wline = (state == WB) ? data[victim] : '0;

  always_comb begin
    state_nx   = state;
    MEM_stall  = 1'b0;
    Dc_mem_req = 1'b0;
    Dc_wb_we   = 1'b0;
    case (state)
      IDLE: begin
        if (miss) begin
          MEM_stall = 1'b1;
          state_nx  = (valid[vsel] && dirty[vsel]) ? WB : FILL;
        end
      end
      WB: begin
        MEM_stall = 1'b1;
        Dc_wb_we  = 1'b1;
        if (Dc_wb_ready) state_nx = FILL;
      end
      FILL: begin
        MEM_stall  = 1'b1;
        Dc_mem_req = 1'b1;
        if (MEM_mem_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state: valid/dirty, replacement pointer, miss latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      rr        <= '0;
      miss_line <= '0;
      victim    <= '0;
    end else begin
      state <= state_nx;
      if (miss) begin
        miss_line <= line;
        victim    <= vsel;
      end
      if (hit && MEM_str) dirty[hit_idx] <= 1'b1;
      if (state == WB && Dc_wb_ready) dirty[victim] <= 1'b0;
      if (state == FILL && MEM_mem_valid) begin
        valid[victim] <= 1'b1;
        dirty[victim] <= 1'b0;
        // Pointer only advances when the fill lands on it, so invalid-slot
        // fills after reset do not disturb the round-robin order.
        if (victim == rr) rr <= rr + 1'b1;
      end
    end
  end

  // Payload arrays need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (hit && MEM_str)
      data[hit_idx][offset] <= MEM_byt ? {cur_word[XLEN-1:8], MEM_b2[7:0]} : MEM_b2;
    if (state == FILL && MEM_mem_valid) begin
      data[victim] <= MEM_data_line;
      tag[victim]  <= miss_line;
    end
  end

`ifdef DCACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Dc_hit_cnt  <= '0;
      Dc_miss_cnt <= '0;
    end else begin
      if (hit && Dc_hit_cnt != '1)   Dc_hit_cnt  <= Dc_hit_cnt + 1'b1;
      if (miss && Dc_miss_cnt != '1) Dc_miss_cnt <= Dc_miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc -- randomized scoreboard bench for dcache_assoc.
// Reference: a flat word memory (what loads must see), a backing memory
// (what the outside world holds), and a slot-level view of which lines are
// cached to predict hits, victims and write-backs.
module tb_dcache_assoc;
  localparam int XLEN = 32, LINES = 4, WORDS = 4, LADDR = 10, LW = WORDS*XLEN;

  logic             clk = 1'b0, rst = 1'b1;
  logic             MEM_ld = 0, MEM_str = 0, MEM_byt = 0;
  logic [XLEN-1:0]  MEM_alu_out = '0, MEM_b2 = '0;
  logic [XLEN-1:0]  MEM_data_mem;
  logic             MEM_stall, Dc_mem_req, Dc_wb_we;
  logic [LADDR-1:0] Dc_mem_addr, Dc_wb_addr;
  logic [LW-1:0]    MEM_data_line = '0, Dc_wb_wline;
  logic             MEM_mem_valid = 0, Dc_wb_ready = 0;
`ifdef DCACHE_PERF_EN
  logic [31:0]      hit_cnt, miss_cnt;
`endif

  dcache_assoc #(.XLEN(XLEN), .LINES(LINES), .WORDS(WORDS), .LADDR(LADDR)) dut (
    .clk(clk), .rst(rst), .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
    .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2), .MEM_data_mem(MEM_data_mem),
    .MEM_stall(MEM_stall), .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Dc_wb_ready(Dc_wb_ready)
`ifdef DCACHE_PERF_EN
    , .Dc_hit_cnt(hit_cnt), .Dc_miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] gold [int];   // architectural view
  logic [XLEN-1:0] bmem [int];   // backing store
  int  m_tag [LINES];
  bit  m_valid [LINES], m_dirty [LINES];
  int  m_rr = 0, hit_n = 0, miss_n = 0;

  logic [XLEN-1:0] exp_q [$];
  int              exp_wb [$], exp_fill [$];

  int fill_force = -1, wb_force = -1, last_wb_cycles = 0;
  bit spurious = 0;

  function automatic logic [XLEN-1:0] get_b(int a);
    if (bmem.exists(a)) return bmem[a];
    return XLEN'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic logic [XLEN-1:0] get_g(int a);
    if (gold.exists(a)) return gold[a];
    return get_b(a);
  endfunction

  function automatic logic [LW-1:0] line_of(int ln, bit from_gold);
    logic [LW-1:0] l;
    for (int w = 0; w < WORDS; w++)
      l[w*XLEN +: XLEN] = from_gold ? get_g(ln*WORDS + w) : get_b(ln*WORDS + w);
    return l;
  endfunction

  function automatic int m_lookup(int ln);
    for (int i = 0; i < LINES; i++) if (m_valid[i] && m_tag[i] == ln) return i;
    return -1;
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < LINES; i++) if (!m_valid[i]) return i;
    return m_rr;
  endfunction

  // After a reset the cache is empty and every dirty word is lost, so the
  // architectural view falls back to the backing store.
  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    m_rr = 0; hit_n = 0; miss_n = 0;
    gold.delete();
    exp_q.delete(); exp_wb.delete(); exp_fill.delete();
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int cnt, dly, wbc;
    cnt = 0; wbc = 0; dly = 0;
    forever begin
      @(posedge clk); #1;
      MEM_mem_valid = 0;
      Dc_wb_ready   = 0;
      if (rst || (!Dc_mem_req && !Dc_wb_we)) begin
        cnt = 0; wbc = 0;
        dly = $urandom_range(0, 3);
        if (spurious && !rst) begin
          MEM_data_line = {WORDS{32'hDEADBEEF}};
          MEM_mem_valid = 1;
          spurious = 0;
        end
      end else if (Dc_mem_req) begin
        if (cnt >= ((fill_force >= 0) ? fill_force : dly)) begin
          MEM_data_line = line_of(int'(Dc_mem_addr), 0);
          MEM_mem_valid = 1;
          if (exp_fill.size() == 0) begin
            vectors++; errors++;
            $display("FAIL fill_addr: unexpected refill of %0h", Dc_mem_addr);
          end else chk("fill_addr", LW'(Dc_mem_addr), LW'(exp_fill.pop_front()));
          cnt = 0;
        end else cnt++;
      end else begin
        wbc++;
        if (cnt >= ((wb_force >= 0) ? wb_force : dly)) begin
          Dc_wb_ready = 1;
          last_wb_cycles = wbc;
          if (exp_wb.size() == 0) begin
            vectors++; errors++;
            $display("FAIL wb_addr: unexpected write-back of %0h", Dc_wb_addr);
          end else begin
            chk("wb_addr", LW'(Dc_wb_addr), LW'(exp_wb.pop_front()));
            chk("wb_line", Dc_wb_wline, line_of(int'(Dc_wb_addr), 1));
          end
          for (int w = 0; w < WORDS; w++)
            bmem[int'(Dc_wb_addr)*WORDS + w] = Dc_wb_wline[w*XLEN +: XLEN];
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst && (MEM_ld || MEM_str) && !MEM_stall) begin
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL resp: unexpected completion, data %0h", MEM_data_mem);
      end else chk("resp", LW'(MEM_data_mem), LW'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    @(posedge clk); #1;
    MEM_ld = 0; MEM_str = 0; MEM_byt = 0;
  endtask

  task automatic access(bit ld, bit st, bit byt, int addr, logic [XLEN-1:0] wd);
    int ln, idx, v, n;
    bit miss;
    logic [XLEN-1:0] cur;
    ln = addr / WORDS; v = 0; n = 0;
    @(posedge clk); #1;
    cur  = get_g(addr);
    idx  = m_lookup(ln);
    miss = (idx < 0);
    if (miss) begin
      v = m_victim();
      if (m_valid[v] && m_dirty[v]) exp_wb.push_back(m_tag[v]);
      exp_fill.push_back(ln);
      miss_n++;
    end
    hit_n++;
    exp_q.push_back(ld ? (byt ? {24'h0, cur[7:0]} : cur) : XLEN'(addr));
    MEM_ld = ld; MEM_str = st; MEM_byt = byt; MEM_alu_out = XLEN'(addr); MEM_b2 = wd;
    forever begin
      @(negedge clk);
      if (n == 0) chk("stall_on_lookup", LW'(MEM_stall), LW'(miss));
      if (!MEM_stall) break;
      if (++n > 300) begin
        vectors++; errors++;
        $display("FAIL access_timeout: addr %0h still stalled, want completion", addr);
        break;
      end
    end
    chk("wb_pending", LW'(exp_wb.size()), '0);
    chk("fill_pending", LW'(exp_fill.size()), '0);
    exp_wb.delete(); exp_fill.delete();
    if (miss) begin
      m_valid[v] = 1; m_dirty[v] = 0; m_tag[v] = ln;
      if (v == m_rr) m_rr = (m_rr + 1) % LINES;
      idx = v;
    end
    if (st) begin
      gold[addr] = byt ? {cur[XLEN-1:8], wd[7:0]} : wd;
      m_dirty[idx] = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mem_req", LW'(Dc_mem_req), '0);
    chk("rst_wb_we", LW'(Dc_wb_we), '0);
    chk("rst_wb_addr", LW'(Dc_wb_addr), '0);
    chk("rst_wb_wline", Dc_wb_wline, '0);
    chk("rst_stall", LW'(MEM_stall), '0);

    // Cold load miss, refill of line 4, replayed hit.
    bmem[32'h10] = 32'hAABBCCDD;
    access(1, 0, 0, 32'h10, '0);
    // Byte store on hit, then word and byte loads.
    access(0, 1, 1, 32'h10, 32'h0000_0012);
    access(1, 0, 0, 32'h10, '0);
    access(1, 0, 1, 32'h10, '0);
    chk("byte_store_word", LW'(get_g(32'h10)), LW'(32'hAABBCC12));

    // Lines 5..7 fill the rest; line 8 evicts dirty line 4 with slow ready.
    for (int l = 5; l <= 7; l++) access(1, 0, 0, l*WORDS, '0);
    wb_force = 3;
    access(1, 0, 0, 8*WORDS + 2, '0);
    wb_force = -1;
    chk("wb_hold_cycles", LW'(last_wb_cycles), LW'(4));
    idle();

    // Refill strobe while idle must be ignored.
    spurious = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spurious_req", LW'(Dc_mem_req), '0);
    chk("spurious_stall", LW'(MEM_stall), '0);
    access(1, 0, 0, 8*WORDS + 1, '0);
    access(1, 0, 0, 9*WORDS, '0);   // victim must still follow the pointer

    // Dirty line 8, then reset in the middle of a refill.
    access(0, 1, 0, 8*WORDS + 1, 32'hCAFEF00D);
    idle();
    fill_force = 40;
    @(posedge clk); #1;
    MEM_ld = 1; MEM_alu_out = 12*WORDS;
    repeat (3) @(negedge clk);
    chk("fill_req_held", LW'(Dc_mem_req), LW'(1));
    chk("fill_addr_held", LW'(Dc_mem_addr), LW'(12));
    @(posedge clk); #1; rst = 1; MEM_ld = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_fill_req", LW'(Dc_mem_req), '0);
    chk("rst_fill_we", LW'(Dc_wb_we), '0);
    fill_force = -1;
    model_reset();
    access(1, 0, 0, 8*WORDS + 1, '0);   // misses, dirty store was dropped

    // Randomized traffic over eight lines to force steady eviction.
    for (int k = 0; k < 400; k++) begin
      int op;
      op = $urandom_range(0, 3);
      access(op != 1, op == 1 || op == 2, $urandom_range(0, 3) == 0,
             $urandom_range(0, 8*WORDS - 1), $urandom);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    @(negedge clk);
`ifdef DCACHE_PERF_EN
    chk("hit_cnt", LW'(hit_cnt), LW'(hit_n));
    chk("miss_cnt", LW'(miss_cnt), LW'(miss_n));
`endif
    chk("resp_drained", LW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
